// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd
// Sequential double-dabble (shift-add-3) binary to packed BCD converter.
// One input bit is consumed per clock, so a conversion takes BIN_W cycles.
// The last completed result is held on bcd between conversions so a display
// driver can read it continuously.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous reset, active-low
//   in_valid   bin is presented for conversion
//   bin        unsigned binary value, sampled only when accepted
//   in_ready   idle, a new value will be accepted on the next edge
//   busy       conversion in progress (always ~in_ready)
//   out_valid  one-cycle pulse: bcd has just been updated
//   bcd        packed BCD result, digit 0 (ones) in bits [3:0]
//
// State table:
//   state | meaning
//   IDLE  | waiting for in_valid; bcd holds the last result
//   SHIFT | shifting bin into the BCD scratch, one bit per clock
module seq_bin2bcd #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BIN_W-1:0]      bin,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The largest binary input must fit in the requested number of digits.
  if ((2 ** BIN_W) - 1 >= 10 ** DIGITS) begin : gCfgCheck
    $error("seq_bin2bcd: BIN_W too wide for DIGITS");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stateT;

  stateT              state;
  stateT              stateNext;

  logic [BIN_W-1:0]   shiftReg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratchAdj;
  logic [BCD_W-1:0]   scratchNext;
  logic [CNT_W-1:0]   bitCnt;
  logic [BCD_W-1:0]   bcdReg;
  logic               outValidReg;
  logic               lastBit;

  assign lastBit = (state == SHIFT) && (bitCnt == CNT_ONE);

  // Add-3 correction on every digit that is 5 or more, all in parallel, then
  // shift left one place with the binary MSB entering the ones digit. Digits
  // entering the add are at most 9, so the 4-bit sum never wraps.
  always_comb begin
    scratchAdj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratchAdj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratchNext = (scratchAdj << 1) | BCD_W'(shiftReg[BIN_W-1]);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid) stateNext = SHIFT;
      SHIFT:   if (lastBit)  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: shift register, scratch digits, bit down-counter, result hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg    <= '0;
      scratch     <= '0;
      bitCnt      <= '0;
      bcdReg      <= '0;
      outValidReg <= 1'b0;
    end else begin
      outValidReg <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shiftReg <= bin;
            scratch  <= '0;
            bitCnt   <= CNT_LOAD;
          end
        end
        SHIFT: begin
          scratch  <= scratchNext;
          shiftReg <= shiftReg << 1;
          bitCnt   <= bitCnt - CNT_ONE;
          // Only the final, fully shifted value ever reaches bcd.
          if (lastBit) begin
            bcdReg      <= scratchNext;
            outValidReg <= 1'b1;
          end
        end
        default: begin
          bitCnt <= '0;
        end
      endcase
    end
  end

  // Outputs are purely registered/state-decoded; nothing from in_valid or bin
  // reaches them combinationally.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SHIFT);
    out_valid = outValidReg;
    bcd       = bcdReg;
  end

endmodule

// File: tb/tb_seq_bin2bcd.sv
module tb_seq_bin2bcd;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [12:0] bin;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [15:0] bcd;

  typedef struct {
    logic [15:0] expBcd;
    int          accCyc;
  } sbEntryT;

  sbEntryT     sbQ[$];
  sbEntryT     monEntry;
  logic [15:0] curExp;
  int          cyc;
  int          checks;
  int          failures;

  seq_bin2bcd #(.BIN_W(13), .DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bin       (bin),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard push: record the expected result at the acceptance edge.
  always @(posedge clk) begin
    if (rst && in_valid && in_ready) begin
      sbQ.push_back('{expBcd: curExp, accCyc: cyc});
    end
    cyc++;
  end

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    logic notReady;
    notReady = ~in_ready;
    if (rst) check("busy_eq_not_ready", {31'b0, busy}, {31'b0, notReady});
    if (rst && out_valid) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: bcd=0x%0h with no pending value", bcd);
      end else begin
        monEntry = sbQ.pop_front();
        check("bcd_value", {16'b0, bcd}, {16'b0, monEntry.expBcd});
        check("latency", cyc - 1 - monEntry.accCyc, 32'd13);
      end
    end
  end

  // Present a value and return at the negedge after it is accepted.
  task automatic send(input logic [12:0] v, input logic [15:0] e);
    bit sampled;
    int n;
    n = 0;
    in_valid = 1'b1;
    bin      = v;
    curExp   = e;
    do begin
      sampled = in_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!sampled && n < 40);
    if (!sampled) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: value %0d never accepted", v);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results still pending", sbQ.size());
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  logic [12:0] bndV [6];
  logic [15:0] bndE [6];
  logic [12:0] strV [20];
  logic [15:0] strE [20];

  initial begin
    int lowCount;

    bndV = '{13'd0, 13'd9, 13'd10, 13'd999, 13'd1000, 13'd8191};
    bndE = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h1000, 16'h8191};
    strV = '{13'd5, 13'd17, 13'd88, 13'd123, 13'd456, 13'd789, 13'd1024, 13'd2048,
             13'd3333, 13'd4096, 13'd5000, 13'd6001, 13'd7777, 13'd8000, 13'd8190,
             13'd99, 13'd100, 13'd4999, 13'd55, 13'd2500};
    strE = '{16'h0005, 16'h0017, 16'h0088, 16'h0123, 16'h0456, 16'h0789, 16'h1024, 16'h2048,
             16'h3333, 16'h4096, 16'h5000, 16'h6001, 16'h7777, 16'h8000, 16'h8190,
             16'h0099, 16'h0100, 16'h4999, 16'h0055, 16'h2500};

    checks   = 0;
    failures = 0;
    cyc      = 0;
    curExp   = '0;
    rst      = 1'b1;
    in_valid = 1'b1;
    bin      = 13'd99;

    // Reset held for 3 cycles with in_valid asserted.
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bcd", {16'b0, bcd}, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);

    // Release with 1234 presented: accepted on the very next edge.
    bin    = 13'd1234;
    curExp = 16'h1234;
    rst    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_after_release", {31'b0, in_ready}, 32'h0);
    lowCount = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
      lowCount++;
    end
    check("ready_low_cycles", lowCount, 32'd13);
    waitIdle();
    repeat (5) @(negedge clk);
    check("bcd_held_1234", {16'b0, bcd}, 32'h1234);
    check("out_valid_idle", {31'b0, out_valid}, 32'h0);

    // Boundary values, one at a time.
    for (int i = 0; i < 6; i++) begin
      send(bndV[i], bndE[i]);
      in_valid = 1'b0;
      waitIdle();
    end

    // in_valid held with bin=7 while busy: ignored until the out_valid cycle.
    send(13'd4095, 16'h4095);
    send(13'd7, 16'h0007);
    in_valid = 1'b0;
    waitIdle();
    check("bcd_after_busy_ignore", {16'b0, bcd}, 32'h0007);

    // Back-to-back stream with in_valid held high.
    for (int i = 0; i < 20; i++) begin
      send(strV[i], strE[i]);
    end
    in_valid = 1'b0;
    waitIdle();

    // Reset in the middle of a conversion.
    send(13'd5678, 16'h5678);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_bcd", {16'b0, bcd}, 32'h0);
    check("midreset_out_valid", {31'b0, out_valid}, 32'h0);
    check("midreset_in_ready", {31'b0, in_ready}, 32'h1);
    sbQ.delete();
    repeat (3) @(negedge clk);
    check("midreset_hold_bcd", {16'b0, bcd}, 32'h0);
    rst = 1'b1;
    send(13'd42, 16'h0042);
    in_valid = 1'b0;
    waitIdle();
    check("bcd_after_midreset", {16'b0, bcd}, 32'h0042);

    repeat (20) @(negedge clk);
    check("no_pending_results", sbQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
